// File: rtl/hazard_scoreboard.sv
// Forwarding-select, Decode-stall and MDU busy-timer controller for NS producer stages.
// Define STALL_PERF_EN to build the saturating stall performance counter on stall_cnt.
module hazard_scoreboard #(
   parameter int NS       = 3,
   parameter int AW       = 5,
   parameter int TW       = 2,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int SEL_W    = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [AW-1:0]    d_ra1,
   input  logic [AW-1:0]    d_ra2,
   input  logic [TW-1:0]    tuse1,
   input  logic [TW-1:0]    tuse2,
   input  logic             d_mdu_class,
   input  logic [NS*AW-1:0] stg_waddr,
   input  logic [NS-1:0]    stg_we,
   input  logic [NS*TW-1:0] stg_tnew,
   input  logic             mdu_start,
   input  logic             mdu_is_div,
   input  logic             int_exc_req,
   output logic [SEL_W-1:0] fwd_sel1,
   output logic [SEL_W-1:0] fwd_sel2,
   output logic             stall,
   output logic             mdu_busy,
   output logic [31:0]      stall_cnt
);

   localparam int CW = $clog2(DIV_LAT + 1);

   typedef struct packed {
      logic             hit;
      logic [SEL_W-1:0] sel;
      logic [TW-1:0]    tnew;
   } lookup_t;

   // Scan oldest to youngest so the youngest matching producer is the one kept.
   function automatic lookup_t lookup(input logic [AW-1:0]    ra,
                                      input logic [NS-1:0]    we,
                                      input logic [NS*AW-1:0] waddr,
                                      input logic [NS*TW-1:0] tnew);
      lookup_t r;
      r = '0;
      for (int i = NS - 1; i >= 0; i--) begin
         if (we[i] && (waddr[i*AW +: AW] == ra)) begin
            r.hit  = 1'b1;
            r.sel  = SEL_W'(i + 1);
            r.tnew = tnew[i*TW +: TW];
         end
      end
      return r;
   endfunction

   lookup_t         w_lk1, w_lk2;
   logic            w_haz1, w_haz2;
   logic            w_mdu_load;
   logic            w_struct_haz;
   logic [CW-1:0]   r_mdu_cnt;

   always_comb begin
      w_lk1  = lookup(d_ra1, stg_we, stg_waddr, stg_tnew);
      w_lk2  = lookup(d_ra2, stg_we, stg_waddr, stg_tnew);
      fwd_sel1 = ((d_ra1 != '0) && w_lk1.hit && (w_lk1.tnew == '0)) ? w_lk1.sel : '0;
      fwd_sel2 = ((d_ra2 != '0) && w_lk2.hit && (w_lk2.tnew == '0)) ? w_lk2.sel : '0;
      // A miss leaves tnew at 0, which can never exceed tuse.
      w_haz1 = (d_ra1 != '0) && (w_lk1.tnew > tuse1);
      w_haz2 = (d_ra2 != '0) && (w_lk2.tnew > tuse2);
   end

   assign w_mdu_load   = mdu_start && !int_exc_req;
   assign mdu_busy     = (r_mdu_cnt != '0);
   assign w_struct_haz = d_mdu_class && (mdu_busy || w_mdu_load);
   assign stall        = (w_haz1 || w_haz2 || w_struct_haz) && !int_exc_req;

   // A start while busy simply reloads; an in-flight op keeps counting through exceptions.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_mdu_cnt <= '0;
      else if (w_mdu_load)
         r_mdu_cnt <= mdu_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      else if (r_mdu_cnt != '0)
         r_mdu_cnt <= r_mdu_cnt - CW'(1);
   end

`ifdef STALL_PERF_EN
   logic [31:0] r_stall_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_stall_cnt <= '0;
      else if (stall && (r_stall_cnt != 32'hFFFF_FFFF))
         r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign stall_cnt = r_stall_cnt;
`else
   assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard: forwarding, data/structural stall, MDU timer, reset.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  d_ra1, d_ra2;
   logic [1:0]  tuse1, tuse2;
   logic        d_mdu_class;
   logic [14:0] stg_waddr;
   logic [2:0]  stg_we;
   logic [5:0]  stg_tnew;
   logic        mdu_start, mdu_is_div, int_exc_req;
   logic [1:0]  fwd_sel1, fwd_sel2;
   logic        stall, mdu_busy;
   logic [31:0] stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   hazard_scoreboard dut (
      .clk(clk), .reset_n(reset_n),
      .d_ra1(d_ra1), .d_ra2(d_ra2), .tuse1(tuse1), .tuse2(tuse2),
      .d_mdu_class(d_mdu_class),
      .stg_waddr(stg_waddr), .stg_we(stg_we), .stg_tnew(stg_tnew),
      .mdu_start(mdu_start), .mdu_is_div(mdu_is_div), .int_exc_req(int_exc_req),
      .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .stall(stall), .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stages();
      stg_we = '0; stg_waddr = '0; stg_tnew = '0;
      d_ra1 = '0; d_ra2 = '0; tuse1 = '0; tuse2 = '0;
   endtask

   initial begin
      reset_n = 1'b0;
      clear_stages();
      d_mdu_class = 0; mdu_start = 0; mdu_is_div = 0; int_exc_req = 0;
      #2;
      chk("rst_busy", 32'(mdu_busy), 0);
      chk("rst_cnt", stall_cnt, 0);
      chk("rst_stall", 32'(stall), 0);
      step();
      reset_n = 1'b1;
      step();

      // Execute result ready: forward from stage 0.
      stg_we = 3'b001; stg_waddr = {5'd0, 5'd0, 5'd8}; stg_tnew = {2'd0, 2'd0, 2'd0};
      d_ra1 = 8; tuse1 = 1; #1;
      chk("fwd_s0_sel1", 32'(fwd_sel1), 1);
      chk("fwd_s0_stall", 32'(stall), 0);
      stg_tnew = {2'd0, 2'd0, 2'd2}; #1;
      chk("late_s0_sel1", 32'(fwd_sel1), 0);
      chk("late_s0_stall", 32'(stall), 1);

      // Forward from Memory and Writeback stages.
      stg_we = 3'b010; stg_waddr = {5'd0, 5'd8, 5'd0}; stg_tnew = '0; #1;
      chk("fwd_s1_sel1", 32'(fwd_sel1), 2);
      stg_we = 3'b100; stg_waddr = {5'd8, 5'd0, 5'd0}; #1;
      chk("fwd_s2_sel1", 32'(fwd_sel1), 3);
      chk("fwd_s2_stall", 32'(stall), 0);

      // Youngest producer with tnew!=0 blocks the older ready one.
      clear_stages();
      stg_we = 3'b101; stg_waddr = {5'd9, 5'd0, 5'd9}; stg_tnew = {2'd0, 2'd0, 2'd1};
      d_ra2 = 9; tuse2 = 0; #1;
      chk("young_sel2", 32'(fwd_sel2), 0);
      chk("young_stall", 32'(stall), 1);
      tuse2 = 1; #1;
      chk("young_t1_stall", 32'(stall), 0);
      chk("young_t1_sel2", 32'(fwd_sel2), 0);

      // Register 0 never forwards or stalls.
      clear_stages();
      stg_we = 3'b111; stg_waddr = '0; stg_tnew = {2'd2, 2'd2, 2'd2};
      d_ra1 = 0; tuse1 = 0; #1;
      chk("r0_sel1", 32'(fwd_sel1), 0);
      chk("r0_stall", 32'(stall), 0);

      // Div: busy T+1..T+10, stall T..T+10.
      clear_stages();
      d_mdu_class = 1; mdu_start = 1; mdu_is_div = 1; #1;
      chk("div_T_stall", 32'(stall), 1);
      chk("div_T_busy", 32'(mdu_busy), 0);
      step();
      mdu_start = 0;
      for (int k = 1; k <= 10; k++) begin
         chk($sformatf("div_busy_%0d", k), 32'(mdu_busy), 1);
         chk($sformatf("div_stall_%0d", k), 32'(stall), 1);
         step();
      end
      chk("div_end_busy", 32'(mdu_busy), 0);
      chk("div_end_stall", 32'(stall), 0);

      // Mult: busy 5 cycles.
      mdu_start = 1; mdu_is_div = 0;
      step();
      mdu_start = 0;
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("mul_busy_%0d", k), 32'(mdu_busy), 1);
         step();
      end
      chk("mul_end_busy", 32'(mdu_busy), 0);
      chk("mul_end_stall", 32'(stall), 0);

      // Start cancelled by exception.
      mdu_start = 1; int_exc_req = 1; #1;
      chk("exc_start_stall", 32'(stall), 0);
      step();
      mdu_start = 0; int_exc_req = 0; #1;
      chk("exc_start_busy", 32'(mdu_busy), 0);
      chk("exc_start_stall2", 32'(stall), 0);
      d_mdu_class = 0;

      // Data hazard masked by exception.
      stg_we = 3'b001; stg_waddr = {5'd0, 5'd0, 5'd8}; stg_tnew = {2'd0, 2'd0, 2'd2};
      d_ra1 = 8; tuse1 = 0; int_exc_req = 1; #1;
      chk("exc_haz_stall", 32'(stall), 0);
      int_exc_req = 0; #1;
      chk("haz_stall", 32'(stall), 1);
      clear_stages();

      // Reset mid-div after exactly three stall edges.
      reset_n = 0; #1;
      chk("rst2_cnt", stall_cnt, 0);
      reset_n = 1;
      step();
      d_mdu_class = 1; mdu_start = 1; mdu_is_div = 1;
      step();
      mdu_start = 0;
      step();
      step();
      d_mdu_class = 0;
      step();
      chk("mid_busy", 32'(mdu_busy), 1);
`ifdef STALL_PERF_EN
      chk("perf_cnt3", stall_cnt, 3);
`else
      chk("perf_cnt_off", stall_cnt, 0);
`endif
      reset_n = 0; #1;
      chk("mid_rst_busy", 32'(mdu_busy), 0);
      chk("mid_rst_cnt", stall_cnt, 0);
      reset_n = 1;
      step();
      chk("post_rst_busy", 32'(mdu_busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline's forwarding and stall controller.
- Serves a processor with NS result-producing stages behind Decode: computes forwarding selects for Decode's two source reads and raises the Decode stall.
- Owns the multiply/divide unit (MDU) busy timer internally, replacing the externally supplied busy flag, with separate mult and div latencies.
- Sits beside the pipeline registers; forwarding and stall logic are combinational, the MDU timer and the stall performance counter are sequential.

Parameters:
- NS, 3, number of producer stages after Decode (index 0 = Execute, youngest; NS-1 = Writeback, oldest)
- AW, 5, register address width
- TW, 2, width of Tnew/Tuse values
- MULT_LAT, 5, MDU busy cycles for mult/multu/mthi/mtlo
- DIV_LAT, 10, MDU busy cycles for div/divu
- SEL_W, 2, forwarding select width; must satisfy 2^SEL_W >= NS+1

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- d_ra1, d_ra2  in  AW each  Decode source register addresses
- tuse1, tuse2  in  TW each  Decode Tuse per source
- d_mdu_class  in  1  Decode instruction accesses the MDU (mult/div/mf/mt)
- stg_waddr  in  NS*AW  flattened destination addresses, stage i at bits [i*AW +: AW]
- stg_we  in  NS  stage i writes a register
- stg_tnew  in  NS*TW  flattened Tnew per stage
- mdu_start  in  1  Execute issues an MDU operation this cycle
- mdu_is_div  in  1  qualifies mdu_start: 1 = div latency, 0 = mult latency
- int_exc_req  in  1  interrupt/exception being taken
- fwd_sel1, fwd_sel2  out  SEL_W each  0 = register file, i+1 = stage i result
- stall  out  1  freeze PC/IF/ID, bubble into Execute
- mdu_busy  out  1  MDU timer nonzero
- stall_cnt  out  32  stall performance counter (STALL_PERF_EN only)

Behaviour:
- Forwarding, per source s:
  - ra_s == 0 -> sel 0.
  - Otherwise choose the lowest-index (youngest) stage i with stg_we[i], waddr == ra_s and tnew == 0; sel = i+1.
  - If none matches -> sel 0.
  - A younger matching stage with tnew != 0 blocks forwarding from older stages: sel 0, and the stall below covers that case.
- Data hazard, per source s:
  - Tnew_s = tnew of the youngest stage with we and an address match; 0 if no stage matches.
  - Hazard when ra_s != 0 and Tnew_s > tuse_s (unsigned compare).
- MDU timer: internal counter of width clog2(DIV_LAT+1), reset 0.
  - A cycle with mdu_start=1 and int_exc_req=0 loads DIV_LAT if mdu_is_div, else MULT_LAT.
  - Otherwise the counter decrements while nonzero.
  - mdu_start while busy is a protocol error; the counter reloads anyway.
  - mdu_start together with int_exc_req is cancelled: no load, and the counter still decrements.
  - An MDU operation already running at exception entry continues counting.
  - mdu_busy = (count != 0), registered.
- Structural hazard: d_mdu_class && (mdu_busy || (mdu_start && !int_exc_req)).
- stall = (data hazard on either source || structural hazard) && !int_exc_req. Purely combinational from current inputs and state.
- Reset mid-operation: the counter clears to 0 asynchronously, mdu_busy drops immediately, and stall_cnt clears.
- Reset values: mdu_busy=0, stall_cnt=0. fwd_sel and stall follow their inputs.

Optional Feature:
- STALL_PERF_EN defined:
  - stall_cnt increments by 1 on every clk edge where stall=1, and saturates at 32'hFFFF_FFFF.
  - Async clear by reset_n.
- STALL_PERF_EN undefined:
  - Counter logic is removed.
  - stall_cnt is tied to 32'h0 so the port list stays fixed.

Test Plan:
- Stage 0 {we=1, waddr=8, tnew=0}, d_ra1=8, tuse1=1 -> fwd_sel1=1, stall=0. Same with stage 0 tnew=2 -> fwd_sel1=0, stall=1.
- Stage 0 {we=1, waddr=9, tnew=1} and stage 2 {we=1, waddr=9, tnew=0}, d_ra2=9, tuse2=0 -> fwd_sel2=0, stall=1 (youngest producer wins). Set tuse2=1 -> stall=0, fwd_sel2=0.
- d_ra1=0 with every stage writing reg 0 at tnew=2 -> fwd_sel1=0, stall=0.
- mdu_start=1, mdu_is_div=1 at cycle T, then d_mdu_class=1 held -> stall=1 in cycle T, mdu_busy=1 for cycles T+1..T+10, stall falls at T+11. Repeat with mdu_is_div=0 -> busy for 5 cycles.
- mdu_start=1 together with int_exc_req=1 -> mdu_busy stays 0 and stall=0. Also, with a hazard present and int_exc_req=1 -> stall=0.
- Start a div, assert reset_n=0 mid-count at cycle T+4 -> mdu_busy=0 immediately. With STALL_PERF_EN, 3 stall cycles before the reset give stall_cnt=3, then 0 after reset.
